pipelined_ripple_adder: RTL and testbench
=========================================

# pipelined_ripple_adder

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready stream interface. The N-bit operation is split into STAGES equal chunks. Each chunk is a ripple chain, with a registered carry between chunks, so one operation is accepted per cycle at a clock period bounded by N/STAGES full-adder delays. The block sits in the arithmetic datapath as the drop-in clocked replacement for the single-cycle combinational ripple adder, adding subtract mode and backpressure.

## Interface
- N, 32, operand/sum width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry chunks; 1 ≤ STAGES ≤ N.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in1  in  N  operand A.
- in2  in  N  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: A+B+cin; 1: A−B−cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  N  result, modulo 2^N.
- cout  out  1  carry out of bit N−1 (for sub: 1 = no borrow).
- overflow  out  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- Effective operands: B' = sub ? ~in2 : in2; c0 = sub ? ~cin : cin. Result = A + B' + c0 computed as W = N/STAGES-bit chunks.
- Stage k (1..STAGES) adds chunk k−1 (bits [kW−1:(k−1)W]) of A and B' with the carry registered by stage k−1 (stage 1 uses c0). It registers the chunk sum, the carry out, the already-finished lower sum bits, and the still-unadded upper A/B' bits.
- The final stage additionally registers the MSB carry-in for overflow. For STAGES=N, W=1 and the MSB carry-in is the stage-N carry-in.
- Each stage holds its own valid bit. Stage k loads when its valid is 0 or stage k+1 loads in the same cycle; the last stage loads when out_valid is 0 or out_ready is 1.
- in_ready = stage-1 load condition. A beat transfers on in_valid & in_ready.
- Output = last-stage registers. out_valid is the last-stage valid. sum/cout/overflow hold stable while out_valid & ~out_ready.
- Beats leave in order. No beat is dropped or duplicated. Bubbles are squeezed out (a stage with valid 0 always loads).

## Timing
- Latency: exactly STAGES cycles from accept to out_valid with out_ready held high.
- Throughput: 1 beat/cycle with out_ready held high.
- in_ready is combinational from out_ready and the stage valids (ready chain). There is no combinational path from in_valid/in1/in2 to any output.
- Full pipe (all STAGES valid) and out_ready=0 → in_ready=0. The same cycle out_ready=1 → in_ready=1 (simultaneous pop and push).
- Reset: all stage valids, out_valid, sum, cout, overflow, and internal data registers are 0. in_ready = 1 while rst deasserted after reset.
- rst asserted mid-operation discards all in-flight beats asynchronously. The first output after release comes from a beat accepted after release.
- Arithmetic wraps modulo 2^N. cout and overflow are independent: both, either, or neither may be set.

## Structure
- Sub-module adder_stage (parameter W): combinational W-bit ripple chain of the existing fa cell. Outputs chunk sum, carry out, and carry into its MSB. It is instantiated STAGES times in a generate loop, with the registers in the parent.
- Shared package/header adder_pkg: the N % STAGES legality check macro/function, the default widths, and the sub encoding constants (OP_ADD=0, OP_SUB=1), shared with the other adders.

## Test plan
- Reset, then N=32, STAGES=4, out_ready=1: in1=0xFFFF_FFFF, in2=0x0000_0001, cin=0, sub=0 → after 4 cycles sum=0, cout=1, overflow=0 (carry ripples across all chunk boundaries).
- in1=0x7FFF_FFFF, in2=1, sub=0 → sum=0x8000_0000, cout=0, overflow=1. Then in1=5, in2=7, sub=1, cin=0 → sum=0xFFFF_FFFE, cout=0, overflow=0.
- Back-to-back stream of 100 random beats with out_ready=1 → one result per cycle after 4-cycle latency, every result matches the reference model, order preserved.
- out_ready=0 with in_valid held → exactly 4 beats accepted, then in_ready=0 and the output stays stable. Release out_ready → all beats emerge in order with no loss.
- Assert rst with 3 beats in flight → out_valid=0, sum=0, cout=0, overflow=0 immediately. None of the 3 beats appear after release.
- Parameter sweep {N,STAGES} = {8,1}, {8,8}, {16,2}, {64,4}: run random add/sub → latency equals STAGES and all results match the model.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: constants and helpers shared by the adder family.
//   DEFAULT_N / DEFAULT_STAGES : default operand width and pipeline depth
//   OP_ADD / OP_SUB            : encoding of the 'sub' mode input
//   stages_legal()             : true when N splits evenly into STAGES chunks
package adder_pkg;

    localparam int unsigned DEFAULT_N      = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic bit stages_legal(input int unsigned n, input int unsigned stages);
        return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// adder_stage: combinational W-bit ripple chain built from fa cells.
//   a, b  : W-bit chunk operands
//   cin   : carry into bit 0
//   sum   : W-bit chunk sum
//   cout  : carry out of bit W-1
//   cmsb  : carry into bit W-1 (used for signed overflow)
module adder_stage #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    // Carries live in per-bit generate scopes so the chain is not one
    // self-referencing vector.
    for (genvar i = 0; i < W; i++) begin : g_bit
        logic c_in;
        logic c_out;

        if (i == 0) begin : g_first
            assign c_in = cin;
        end else begin : g_next
            assign c_in = g_bit[i-1].c_out;
        end

        fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c_in),
            .s  (sum[i]),
            .co (c_out)
        );
    end

    assign cout = g_bit[W-1].c_out;
    assign cmsb = g_bit[W-1].c_in;

endmodule

// File: rtl/fa.sv
// fa: single-bit full adder cell.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: N-bit adder/subtractor split into STAGES ripple
// chunks with a registered carry between chunks and a valid/ready stream.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : input handshake
//   in1, in2, cin, sub  : operands, carry/borrow in, mode (OP_ADD/OP_SUB)
//   out_valid, out_ready: output handshake
//   sum, cout, overflow : result mod 2^N, carry out of MSB, signed overflow
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int unsigned N      = DEFAULT_N,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         overflow
);

    localparam int unsigned W = N / STAGES;

    if (!stages_legal(N, STAGES)) begin : g_illegal
        $error("pipelined_ripple_adder: N must be a nonzero multiple of STAGES");
    end

    // Per-stage registers. opa_q/opb_q are shifted right by W every stage so
    // the next chunk to add always sits at [W-1:0]; acc_q collects finished
    // chunks from the top down so the last stage holds the full sum.
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [N-1:0]      opa_q [STAGES];
    logic [N-1:0]      opb_q [STAGES];
    logic [N-1:0]      acc_q [STAGES];
    logic              ovf_q;

    // Stage inputs: stage 0 is fed from the ports, stage s from stage s-1.
    logic [N-1:0]      st_a   [STAGES];
    logic [N-1:0]      st_b   [STAGES];
    logic [N-1:0]      st_acc [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;

    logic [W-1:0]      ch_sum  [STAGES];
    logic              ch_cout [STAGES];
    logic              ch_cmsb [STAGES];

    logic [STAGES-1:0] load;

    // Ready chain: an empty stage always loads, a full one only if it drains.
    always_comb begin
        load = '0;
        load[STAGES-1] = ~valid_q[STAGES-1] | out_ready;
        for (int s = int'(STAGES) - 2; s >= 0; s--) begin
            load[s] = ~valid_q[s] | load[s+1];
        end
    end

    always_comb begin
        st_a[0]   = in1;
        st_b[0]   = (sub == OP_ADD) ? in2 : ~in2;
        st_c      = '0;
        st_c[0]   = (sub == OP_SUB) ? ~cin : cin;
        st_acc[0] = '0;
        st_v      = '0;
        st_v[0]   = in_valid;
        for (int s = 1; s < int'(STAGES); s++) begin
            st_a[s]   = opa_q[s-1];
            st_b[s]   = opb_q[s-1];
            st_acc[s] = acc_q[s-1];
            st_c[s]   = carry_q[s-1];
            st_v[s]   = valid_q[s-1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        adder_stage #(
            .W (W)
        ) u_adder_stage (
            .a    (st_a[s][W-1:0]),
            .b    (st_b[s][W-1:0]),
            .cin  (st_c[s]),
            .sum  (ch_sum[s]),
            .cout (ch_cout[s]),
            .cmsb (ch_cmsb[s])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < int'(STAGES); s++) begin
                opa_q[s] <= '0;
                opb_q[s] <= '0;
                acc_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < int'(STAGES); s++) begin
                if (load[s]) begin
                    valid_q[s] <= st_v[s];
                    // Data only moves with a real beat; bubbles leave it alone.
                    if (st_v[s]) begin
                        carry_q[s] <= ch_cout[s];
                        opa_q[s]   <= st_a[s] >> W;
                        opb_q[s]   <= st_b[s] >> W;
                        acc_q[s]   <= (st_acc[s] >> W) | (N'(ch_sum[s]) << (N - W));
                    end
                end
            end
            if (load[STAGES-1] && st_v[STAGES-1]) begin
                ovf_q <= ch_cmsb[STAGES-1] ^ ch_cout[STAGES-1];
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[STAGES-1];
    assign sum       = acc_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Bench for pipelined_ripple_adder: directed literal vectors, a queue-based
// reference model compared every cycle on the 32/4 instance, and a latency +
// result sweep over four other parameterisations.
module tb_pipelined_ripple_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Main 32-bit / 4-stage instance.
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
    logic [31:0] in1, in2, sum;

    pipelined_ripple_adder #(.N(32), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    // Sweep instances share one 64-bit stimulus, truncated per width.
    logic        sw_valid, sw_cin, sw_sub;
    logic [63:0] sw_a, sw_b;
    logic        r0, r1, r2, r3;
    logic        v0, v1, v2, v3;
    logic        c0, c1, c2, c3;
    logic        o0, o1, o2, o3;
    logic [7:0]  s0, s1;
    logic [15:0] s2;
    logic [63:0] s3;

    pipelined_ripple_adder #(.N(8), .STAGES(1)) u_sw0 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r0), .in1(sw_a[7:0]),
        .in2(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v0), .out_ready(1'b1),
        .sum(s0), .cout(c0), .overflow(o0)
    );
    pipelined_ripple_adder #(.N(8), .STAGES(8)) u_sw1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r1), .in1(sw_a[7:0]),
        .in2(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v1), .out_ready(1'b1),
        .sum(s1), .cout(c1), .overflow(o1)
    );
    pipelined_ripple_adder #(.N(16), .STAGES(2)) u_sw2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r2), .in1(sw_a[15:0]),
        .in2(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v2), .out_ready(1'b1),
        .sum(s2), .cout(c2), .overflow(o2)
    );
    pipelined_ripple_adder #(.N(64), .STAGES(4)) u_sw3 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r3), .in1(sw_a),
        .in2(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(v3), .out_ready(1'b1),
        .sum(s3), .cout(c3), .overflow(o3)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    // Reference: plain wide arithmetic on the effective operands.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sb, input int n);
        logic [63:0] mask, am, bb;
        logic        c_in;
        logic [64:0] full;
        res_t        r;
        mask   = (n == 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
        am     = a & mask;
        bb     = (sb ? ~b : b) & mask;
        c_in   = sb ? ~ci : ci;
        full   = {1'b0, am} + {1'b0, bb} + {64'd0, c_in};
        r.sum  = full[63:0] & mask;
        r.cout = full[n];
        r.ovf  = (am[n-1] == bb[n-1]) && (full[n-1] != am[n-1]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard for the main instance.
    res_t exp_q[$];
    int   out_count    = 0;
    int   accept_count = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                out_count++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model({32'd0, in1}, {32'd0, in2}, cin, sub, 32));
                accept_count++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_out: actual sum=%0h required=no output", sum);
            end else begin
                chk("sb_sum", 64'(sum), exp_q[0].sum);
                chk("sb_cout", 64'(cout), 64'(exp_q[0].cout));
                chk("sb_ovf", 64'(overflow), 64'(exp_q[0].ovf));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    // Single beat, then measure latency and compare against literals.
    task automatic send_wait(input string nm, input logic [31:0] a, input logic [31:0] b,
                             input logic ci, input logic sb, input logic [31:0] es,
                             input logic ec, input logic eo);
        int lat;
        in_valid = 1'b1;
        in1 = a;
        in2 = b;
        cin = ci;
        sub = sb;
        chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd4);
        chk({nm, "_sum"}, 64'(sum), 64'(es));
        chk({nm, "_cout"}, 64'(cout), 64'(ec));
        chk({nm, "_ovf"}, 64'(overflow), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_chk(input string nm, input int t, input int st, input int n,
                             input logic [63:0] ta[48], input logic [63:0] tb[48],
                             input logic tc[48], input logic ts[48], input logic v,
                             input logic [63:0] s, input logic c, input logic o);
        int   idx;
        res_t r;
        idx = t - st + 1;
        if (idx >= 0 && idx < 40) begin
            r = model(ta[idx], tb[idx], tc[idx], ts[idx], n);
            chk({nm, "_valid"}, 64'(v), 64'd1);
            chk({nm, "_sum"}, s, r.sum);
            chk({nm, "_cout"}, 64'(c), 64'(r.cout));
            chk({nm, "_ovf"}, 64'(o), 64'(r.ovf));
        end else begin
            chk({nm, "_idle"}, 64'(v), 64'd0);
        end
    endtask

    logic [63:0] ta[48], tb[48];
    logic        tc[48], ts[48];

    initial begin
        int base, base_acc, stalls;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_a      = '0;
        sw_b      = '0;
        sw_cin    = 1'b0;
        sw_sub    = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed literal vectors.
        send_wait("d_carry_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        send_wait("d_pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_wait("d_sub_neg", 32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_wait("d_sub_both", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send_wait("d_add_cin", 32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        send_wait("d_sub_bin", 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Back-to-back random stream.
        base   = out_count;
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in1 = $urandom;
            in2 = $urandom;
            cin = 1'($urandom_range(1));
            sub = 1'($urandom_range(1));
            if (!in_ready) stalls++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_outputs", 64'(out_count - base), 64'd100);
        chk("stream_stalls", 64'(stalls), 64'd0);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: exactly STAGES beats fit, then simultaneous pop/push.
        out_ready = 1'b0;
        base      = out_count;
        base_acc  = accept_count;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in1 = 32'h1000_0000 * i + 32'h0123;
            in2 = 32'h0F00_0000 + i;
            cin = 1'(i);
            sub = 1'(i >> 1);
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", 64'(accept_count - base_acc), 64'd4);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_pushpop_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_outputs", 64'(out_count - base), 64'd5);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in1 = 32'hA5A5_0000 + i;
            in2 = 32'h1111_1111;
            cin = 1'b0;
            sub = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = out_count;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_ghost", 64'(out_count - base), 64'd0);
        send_wait("d_after_rst", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A,
                  1'b0, 1'b0);

        // Parameter sweep: continuous beats, latency and value per config.
        for (int i = 0; i < 48; i++) begin
            ta[i] = {$urandom, $urandom};
            tb[i] = {$urandom, $urandom};
            tc[i] = 1'($urandom_range(1));
            ts[i] = 1'($urandom_range(1));
        end
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        tb[0] = 64'h1;
        tc[0] = 1'b0;
        ts[0] = 1'b0;
        sw_valid = 1'b1;
        sw_a     = ta[0];
        sw_b     = tb[0];
        sw_cin   = tc[0];
        sw_sub   = ts[0];
        for (int t = 0; t < 48; t++) begin
            @(posedge clk);
            #1;
            sweep_chk("sw_8_1", t, 1, 8, ta, tb, tc, ts, v0, 64'(s0), c0, o0);
            sweep_chk("sw_8_8", t, 8, 8, ta, tb, tc, ts, v1, 64'(s1), c1, o1);
            sweep_chk("sw_16_2", t, 2, 16, ta, tb, tc, ts, v2, 64'(s2), c2, o2);
            sweep_chk("sw_64_4", t, 4, 64, ta, tb, tc, ts, v3, s3, c3, o3);
            if (t + 1 < 40) begin
                sw_a   = ta[t+1];
                sw_b   = tb[t+1];
                sw_cin = tc[t+1];
                sw_sub = ts[t+1];
            end else begin
                sw_valid = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
